// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the instruction memory loader: FSM state
// encoding, the NOP word and a small fetch-address helper.
package instr_mem_loader_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  // All-zero instruction word; consumers size it to their own WIDTH.
  localparam logic [63:0] NOP_WORD = 64'h0;

  function automatic logic is_word_aligned(input logic [1:0] byte_off);
    return (byte_off == 2'b00);
  endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Load-port and fetch-port bundle between a boot/CPU master and the
// instruction memory loader.
interface instr_mem_loader_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 6
);

  logic             load_en;
  logic             init_done;
  logic             ld_valid;
  logic [AW-1:0]    ld_addr;
  logic [WIDTH-1:0] ld_data;
  logic             ld_ready;
  logic             fetch_req;
  logic             stall;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] instruction;
  logic             instr_valid;
  logic             fetch_err;

  modport master (
    output load_en, ld_valid, ld_addr, ld_data, fetch_req, stall, pc,
    input  init_done, ld_ready, instruction, instr_valid, fetch_err
  );

  modport slave (
    input  load_en, ld_valid, ld_addr, ld_data, fetch_req, stall, pc,
    output init_done, ld_ready, instruction, instr_valid, fetch_err
  );

endinterface

// File: rtl/instr_mem_array.sv
// DEPTH x WIDTH storage with one synchronous write port and one synchronous,
// enable-gated read port; the read register holds while re is low.
module instr_mem_array #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] rdata_r;

  // Write port: callers only present in-range indices.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read port: capture on enable, hold otherwise.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_r <= mem_r[raddr];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction memory with a zero-fill CLEAR phase, a LOAD phase that accepts
// writes from a loader port, and a RUN phase serving 1-cycle-latency fetches.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input logic               clk,
  input logic               rst,
  instr_mem_loader_if.slave bus
);

  localparam logic [WIDTH-1:0] NOP       = WIDTH'(NOP_WORD);
  localparam logic [AW-1:0]    LAST_IDX  = AW'(DEPTH - 1);
  localparam logic [AW:0]      DEPTH_EXT = (AW + 1)'(DEPTH);
  localparam logic [WIDTH-1:0] DEPTH_W   = WIDTH'(DEPTH);

  state_e           state_r;
  state_e           state_nx_s;
  logic [AW-1:0]    clr_cnt_r;
  logic             ld_ready_r;
  logic             init_done_r;
  logic             instr_valid_r;
  logic             fetch_err_r;
  logic             zero_r;

  logic             we_s;
  logic [AW-1:0]    waddr_s;
  logic [WIDTH-1:0] wdata_s;
  logic             issue_s;
  logic             fetch_bad_s;
  logic             rd_en_s;
  logic             ld_in_range_s;
  logic [WIDTH-1:0] word_idx_s;
  logic [WIDTH-1:0] rd_data_s;

  assign word_idx_s    = bus.pc >> 2;
  assign fetch_bad_s   = !is_word_aligned(bus.pc[1:0]) || (word_idx_s >= DEPTH_W);
  assign ld_in_range_s = ({1'b0, bus.ld_addr} < DEPTH_EXT);
  assign rd_en_s       = issue_s && !fetch_bad_s;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_CLEAR;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Clear counter walks 0..DEPTH-1 while in CLEAR and parks at zero otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_cnt_r <= '0;
    end else if ((state_r == ST_CLEAR) && (clr_cnt_r != LAST_IDX)) begin
      clr_cnt_r <= clr_cnt_r + AW'(1);
    end else begin
      clr_cnt_r <= '0;
    end
  end

  // Next-state logic, write-port mux and fetch issue decode.
  always_comb begin
    state_nx_s = state_r;
    we_s       = 1'b0;
    waddr_s    = clr_cnt_r;
    wdata_s    = NOP;
    issue_s    = 1'b0;
    case (state_r)
      ST_CLEAR: begin
        we_s = 1'b1;
        if (clr_cnt_r == LAST_IDX) begin
          if (bus.load_en) begin
            state_nx_s = ST_LOAD;
          end else begin
            state_nx_s = ST_RUN;
          end
        end else begin
          state_nx_s = ST_CLEAR;
        end
      end
      ST_LOAD: begin
        // Out-of-range indices are still handshaken but never reach the array.
        we_s    = bus.ld_valid && ld_in_range_s;
        waddr_s = bus.ld_addr;
        wdata_s = bus.ld_data;
        if (!bus.load_en) begin
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_LOAD;
        end
      end
      ST_RUN: begin
        issue_s = bus.fetch_req && !bus.stall;
        if (bus.load_en && !bus.stall) begin
          state_nx_s = ST_LOAD;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      default: begin
        state_nx_s = ST_CLEAR;
      end
    endcase
  end

  // Mode status flags, registered from the upcoming state so they track it exactly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_ready_r  <= 1'b0;
      init_done_r <= 1'b0;
    end else begin
      ld_ready_r  <= (state_nx_s == ST_LOAD);
      init_done_r <= (state_nx_s != ST_CLEAR);
    end
  end

  // Fetch result flags; zero_r masks the read data to NOP for bad fetches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_valid_r <= 1'b0;
      fetch_err_r   <= 1'b0;
      zero_r        <= 1'b1;
    end else if (issue_s) begin
      instr_valid_r <= 1'b1;
      fetch_err_r   <= fetch_bad_s;
      zero_r        <= fetch_bad_s;
    end else if (!bus.stall) begin
      instr_valid_r <= 1'b0;
      fetch_err_r   <= 1'b0;
      zero_r        <= zero_r;
    end else begin
      instr_valid_r <= instr_valid_r;
      fetch_err_r   <= fetch_err_r;
      zero_r        <= zero_r;
    end
  end

  instr_mem_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (we_s),
    .waddr (waddr_s),
    .wdata (wdata_s),
    .re    (rd_en_s),
    .raddr (bus.pc[AW+1:2]),
    .rdata (rd_data_s)
  );

  assign bus.ld_ready    = ld_ready_r;
  assign bus.init_done   = init_done_r;
  assign bus.instr_valid = instr_valid_r;
  assign bus.fetch_err   = fetch_err_r;
  assign bus.instruction = zero_r ? NOP : rd_data_s;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: directed scenarios plus randomized
// load/fetch traffic checked against an array-based reference model.
module tb_instr_mem_loader;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 40;
  localparam int AW     = $clog2(DEPTH);
  localparam int M_CLEAR = 0;
  localparam int M_LOAD  = 1;
  localparam int M_RUN   = 2;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             err;
    int               cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             stall_q = 1'b0;
  int               cyc = 0;
  int               checks = 0;
  int               failures = 0;
  int               mode = M_CLEAR;
  exp_t             sb[$];
  logic [WIDTH-1:0] model [DEPTH];

  instr_mem_loader_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  instr_mem_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    stall_q <= bus.stall;
  end

  task automatic chk1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%b required=%b t=%0t", name, act, req, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference: a fetch returns the stored word, or zero with error when the
  // byte address is misaligned or beyond the last word.
  function automatic exp_t model_fetch(input logic [WIDTH-1:0] p);
    exp_t e;
    int unsigned widx;
    widx  = p / 4;
    e.cyc = cyc + 1;
    if ((p % 4) != 0 || widx >= DEPTH) begin
      e.data = '0;
      e.err  = 1'b1;
    end else begin
      e.data = model[widx];
      e.err  = 1'b0;
    end
    return e;
  endfunction

  task automatic step(input logic le, input logic lv, input logic [AW-1:0] la,
                      input logic [WIDTH-1:0] ldat, input logic fr, input logic st,
                      input logic [WIDTH-1:0] p);
    bus.load_en   = le;
    bus.ld_valid  = lv;
    bus.ld_addr   = la;
    bus.ld_data   = ldat;
    bus.fetch_req = fr;
    bus.stall     = st;
    bus.pc        = p;
    if (mode == M_RUN && fr && !st) sb.push_back(model_fetch(p));
    if (mode == M_LOAD && lv && int'(la) < DEPTH) model[int'(la)] = ldat;
    @(posedge clk);
    #1;
    if (mode == M_RUN && le && !st) mode = M_LOAD;
    else if (mode == M_LOAD && !le) mode = M_RUN;
  endtask

  task automatic idle(input logic le);
    step(le, 1'b0, '0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic fetch(input logic [WIDTH-1:0] p);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, p);
  endtask

  task automatic write(input logic le, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    step(le, 1'b1, a, d, 1'b0, 1'b0, '0);
  endtask

  task automatic do_reset(input logic le);
    int n;
    bus.ld_valid  = 1'b0;
    bus.ld_addr   = '0;
    bus.ld_data   = '0;
    bus.stall     = 1'b0;
    bus.pc        = '0;
    bus.fetch_req = 1'b1;
    bus.load_en   = le;
    rst = 1'b0;
    #1;
    chk1("rst_init_done", bus.init_done, 1'b0);
    chk1("rst_ld_ready", bus.ld_ready, 1'b0);
    chk1("rst_instr_valid", bus.instr_valid, 1'b0);
    chk1("rst_fetch_err", bus.fetch_err, 1'b0);
    chkw("rst_instruction", bus.instruction, '0);
    foreach (model[i]) model[i] = '0;
    mode = M_CLEAR;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    while (n < 4 * DEPTH && !bus.init_done) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) chk1("clear_ld_ready", bus.ld_ready, 1'b0);
    end
    chkw("clear_cycles", WIDTH'(n), WIDTH'(DEPTH));
    mode = le ? M_LOAD : M_RUN;
    chk1("post_clear_ld_ready", bus.ld_ready, le);
  endtask

  function automatic logic [WIDTH-1:0] rand_pc();
    logic [WIDTH-1:0] p;
    p = WIDTH'($urandom_range(0, DEPTH - 1)) << 2;
    case ($urandom_range(0, 9))
      0:       p = p | WIDTH'($urandom_range(1, 3));
      1:       p = WIDTH'($urandom_range(DEPTH, DEPTH + 20)) << 2;
      2:       p = $urandom();
      default: p = p;
    endcase
    return p;
  endfunction

  // Monitor: pops on each new result, checks holds under stall and idle rules.
  initial begin : monitor
    exp_t             e;
    logic [WIDTH-1:0] p_instr;
    logic             p_valid;
    logic             p_err;
    p_instr = '0;
    p_valid = 1'b0;
    p_err   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        p_instr = '0;
        p_valid = 1'b0;
        p_err   = 1'b0;
      end else begin
        if (stall_q) begin
          chkw("stall_hold_instr", bus.instruction, p_instr);
          chk1("stall_hold_valid", bus.instr_valid, p_valid);
          chk1("stall_hold_err", bus.fetch_err, p_err);
        end else if (bus.instr_valid) begin
          if (sb.size() == 0) begin
            chk1("spurious_valid", bus.instr_valid, 1'b0);
          end else begin
            e = sb.pop_front();
            chkw("fetch_data", bus.instruction, e.data);
            chk1("fetch_err", bus.fetch_err, e.err);
            chkw("fetch_latency", WIDTH'(cyc), WIDTH'(e.cyc));
          end
        end else begin
          chk1("idle_err", bus.fetch_err, 1'b0);
          chkw("idle_hold_instr", bus.instruction, p_instr);
        end
        p_instr = bus.instruction;
        p_valid = bus.instr_valid;
        p_err   = bus.fetch_err;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin : stimulus
    bus.load_en   = 1'b0;
    bus.ld_valid  = 1'b0;
    bus.ld_addr   = '0;
    bus.ld_data   = '0;
    bus.fetch_req = 1'b0;
    bus.stall     = 1'b0;
    bus.pc        = '0;
    #2;
    do_reset(1'b0);
    fetch(32'h0000_0000);
    idle(1'b0);

    idle(1'b1);
    chk1("load_ld_ready", bus.ld_ready, 1'b1);
    step(1'b1, 1'b0, '0, '0, 1'b1, 1'b0, 32'h0000_0004);
    write(1'b1, 6'd0, 32'h8020_000A);
    write(1'b1, 6'd1, 32'h0440_0800);
    write(1'b0, 6'd2, 32'h1111_1111);
    chk1("run_ld_ready", bus.ld_ready, 1'b0);
    fetch(32'h0000_0000);
    fetch(32'h0000_0004);
    fetch(32'h0000_0008);
    fetch(32'h0000_0002);
    fetch(WIDTH'(DEPTH) << 2);

    fetch(32'h0000_0004);
    repeat (3) step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 32'h0000_0008);
    idle(1'b0);
    idle(1'b0);

    step(1'b1, 1'b0, '0, '0, 1'b1, 1'b0, 32'h0000_0000);
    chk1("run_to_load_ready", bus.ld_ready, 1'b1);
    write(1'b1, AW'(DEPTH), 32'hCAFE_F00D);
    chk1("drop_addr_ready", bus.ld_ready, 1'b1);
    idle(1'b0);
    for (int i = 0; i < DEPTH; i++) fetch(WIDTH'(i) << 2);
    idle(1'b0);

    idle(1'b1);
    write(1'b1, 6'd5, 32'hDEAD_BEEF);
    idle(1'b1);
    chkw("sb_drained_pre_reset", WIDTH'(sb.size()), '0);
    do_reset(1'b0);
    fetch(32'h0000_0014);
    fetch(32'h0000_0000);
    idle(1'b0);

    for (int k = 0; k < 400; k++) begin
      logic             le;
      logic             lv;
      logic             fr;
      logic             st;
      logic [AW-1:0]    la;
      logic [WIDTH-1:0] d;
      logic [WIDTH-1:0] p;
      st = ($urandom_range(0, 4) == 0);
      fr = ($urandom_range(0, 2) != 0);
      lv = ($urandom_range(0, 1) == 1);
      la = AW'($urandom_range(0, (1 << AW) - 1));
      d  = $urandom();
      p  = rand_pc();
      if (mode == M_LOAD) le = ($urandom_range(0, 7) != 0);
      else le = ($urandom_range(0, 15) == 0);
      step(le, lv, la, d, fr, st, p);
    end
    idle(1'b0);
    for (int i = 0; i < DEPTH; i++) fetch(WIDTH'(i) << 2);
    repeat (3) idle(1'b0);
    chkw("sb_empty", WIDTH'(sb.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 Parameter WIDTH, default 32, instruction word width in bits (>= 8).
REQ-002 Parameter DEPTH, default 64, number of instruction words (>= 2; need not be a power of two).
REQ-003 Parameter AW, default $clog2(DEPTH), word-index width; derived, never overridden.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 load_en  in  1  level request to enter or stay in LOAD mode.
REQ-007 ld_valid  in  1  load-write request.
REQ-008 ld_addr  in  AW  load-write word index.
REQ-009 ld_data  in  WIDTH  load-write data.
REQ-010 ld_ready  out  1  load-write accepted this cycle when high with ld_valid.
REQ-011 fetch_req  in  1  fetch request.
REQ-012 stall  in  1  hold fetch outputs.
REQ-013 pc  in  WIDTH  byte address of fetch.
REQ-014 instruction  out  WIDTH  fetched word.
REQ-015 instr_valid  out  1  instruction/fetch_err valid.
REQ-016 fetch_err  out  1  misaligned or out-of-range fetch.
REQ-017 init_done  out  1  high once CLEAR has completed.

Function
REQ-018 FSM states CLEAR, LOAD, RUN; reset state CLEAR.
REQ-019 CLEAR: one word zeroed per cycle, index 0..DEPTH-1 via clear counter; after index DEPTH-1 is written, next state LOAD if load_en=1, else RUN.
REQ-020 CLEAR: ld_ready=0, fetch_req ignored, instr_valid=0.
REQ-021 LOAD: ld_ready=1; write mem[ld_addr]=ld_data when ld_valid=1 and ld_addr<DEPTH; ld_addr>=DEPTH is accepted and dropped.
REQ-022 LOAD -> RUN when load_en=0 at an edge; a write on that same edge still commits.
REQ-023 RUN -> LOAD when load_en=1 and stall=0 at an edge; a fetch issued on that edge still completes.
REQ-024 RUN: ld_ready=0; ld_valid ignored.
REQ-025 Fetch issues when state RUN, fetch_req=1, stall=0; result appears next cycle (latency 1) with instr_valid=1.
REQ-026 Fetch index = pc[AW+1:2]; fetch_err=1 and instruction=0 when pc[1:0]!=0 or pc>>2 >= DEPTH.
REQ-027 Fetch write-after-load: a word written in LOAD is readable by the first RUN fetch.
REQ-028 stall=1: instruction, instr_valid, fetch_err hold their values; no new fetch issues.
REQ-029 stall=0, no fetch issued: instr_valid=0, fetch_err=0, instruction holds last value.
REQ-030 init_done=0 in CLEAR, 1 in LOAD and RUN.

Reset
REQ-031 rst low: state=CLEAR, clear counter=0, instruction=0, instr_valid=0, fetch_err=0, ld_ready=0, init_done=0, immediately and asynchronously.
REQ-032 Reset mid-CLEAR, mid-LOAD or mid-RUN restarts CLEAR from index 0; memory content not reset directly, only by CLEAR.
REQ-033 First CLEAR write occurs on the first rising edge after rst deasserts.

Structure
REQ-034 Shared package holds the state enum (CLEAR/LOAD/RUN) and NOP constant (all-zero word).
REQ-035 One sub-module natural: instr_mem_array (DEPTH x WIDTH, one synchronous write port, one synchronous read port).
REQ-036 Write port muxed between clear counter (CLEAR) and load port (LOAD).

Verification
REQ-037 Reset release, load_en=0 -> init_done rises after DEPTH cycles; fetch pc=0 returns 0, instr_valid=1 next cycle.
REQ-038 LOAD writes idx0=0x8020000A, idx1=0x04400800; drop load_en; fetch pc=0,4 -> 0x8020000A, 0x04400800 on consecutive cycles.
REQ-039 Fetch pc=0x2 and pc=DEPTH*4 -> instruction=0, fetch_err=1, instr_valid=1.
REQ-040 Fetch pc=4 then stall=1 for 3 cycles -> outputs held 3 cycles; no extra fetch issued.
REQ-041 Assert rst during LOAD after writing idx5=0xDEADBEEF -> CLEAR restarts; after RUN, fetch pc=20 returns 0.
REQ-042 ld_addr=DEPTH with ld_valid in LOAD -> ld_ready=1, no memory word changes.
